// File: rtl/ucsbece154b_perf_monitor.sv
//==============================================================================
// Module   : ucsbece154b_perf_monitor
// Brief    : Performance-counter bank (cycle + NUM_EV event counters), saturating,
//            read through a registered address/data port.
//            Define PERF_SNAPSHOT_EN to add a shadow bank and source reads from it.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module ucsbece154b_perf_monitor #(
    parameter int CNT_W  = 32,
    parameter int NUM_EV = 5,
    parameter int ADDR_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_i,
    input  logic                clear_i,
    input  logic                snap_i,
    input  logic [NUM_EV-1:0]   ev_i,
    input  logic                rd_en_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic [CNT_W-1:0]    rd_data_o,
    output logic                rd_valid_o,
    output logic [NUM_EV:0]     sat_o
);

    localparam int NUM_CNT = NUM_EV + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_CNT-1:0][CNT_W-1:0] cnt;
    logic [NUM_CNT-1:0][CNT_W-1:0] rd_src;
    logic [NUM_CNT-1:0]            inc_req;
    logic [NUM_CNT-1:0]            at_max;
    logic [NUM_CNT-1:0]            sat;
    logic [CNT_W-1:0]              rd_sel;
    logic [CNT_W-1:0]              rd_data;
    logic                          rd_valid;

    // Counter 0 (cycles) requests an increment every enabled cycle.
    assign inc_req = {ev_i, 1'b1};

    always_comb begin
        at_max = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            at_max[i] = (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt <= '0;
            sat <= '0;
        end else if (en_i) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (inc_req[i]) begin
                    if (at_max[i]) begin
                        sat[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_ONE;
                    end
                end
            end
        end
    end

`ifdef PERF_SNAPSHOT_EN
    logic [NUM_CNT-1:0][CNT_W-1:0] shadow;

    // cnt holds pre-increment / pre-clear values at the edge, so the copy is coherent.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
        end else if (snap_i) begin
            shadow <= cnt;
        end
    end

    assign rd_src = shadow;
`else
    logic unused_snap;

    assign unused_snap = snap_i;
    assign rd_src      = cnt;
`endif

    // Out-of-range addresses fall through to zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_addr_i == ADDR_W'(i)) begin
                rd_sel = rd_src[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en_i;
            if (rd_en_i) begin
                rd_data <= rd_sel;
            end
        end
    end

    assign rd_data_o  = rd_data;
    assign rd_valid_o = rd_valid;
    assign sat_o      = sat;

endmodule

`default_nettype wire
